// File: rtl/axi_spy_trace.sv
// Passive AXI AR/AW/R/W snooper: timestamped records, per-channel FIFOs, round-robin merge.
// Defining AXI_SPY_ID_FILTER_EN adds id_match/id_mask capture filtering.
module axi_spy_trace #(
   parameter int ID_WIDTH       = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int FIFO_DEPTH     = 4,
   parameter int TS_WIDTH       = 16,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        spy_en,
   input  logic                        cnt_clr,
`ifdef AXI_SPY_ID_FILTER_EN
   input  logic [ID_WIDTH-1:0]         id_match,
   input  logic [ID_WIDTH-1:0]         id_mask,
`endif
   input  logic                        ARVALID,
   input  logic                        ARREADY,
   input  logic [ID_WIDTH-1:0]         ARID,
   input  logic [ADDR_WIDTH-1:0]       ARADDR,
   input  logic                        AWVALID,
   input  logic                        AWREADY,
   input  logic [ID_WIDTH-1:0]         AWID,
   input  logic [ADDR_WIDTH-1:0]       AWADDR,
   input  logic                        RVALID,
   input  logic                        RREADY,
   input  logic                        RLAST,
   input  logic [ID_WIDTH-1:0]         RID,
   input  logic [DATA_WIDTH-1:0]       RDATA,
   input  logic                        WVALID,
   input  logic                        WREADY,
   input  logic                        WLAST,
   input  logic [ID_WIDTH-1:0]         WID,
   input  logic [DATA_WIDTH-1:0]       WDATA,
   output logic                        trc_valid,
   input  logic                        trc_ready,
   output logic [1:0]                  trc_chan,
   output logic [ID_WIDTH-1:0]         trc_id,
   output logic [DATA_WIDTH-1:0]       trc_payload,
   output logic                        trc_last,
   output logic [TS_WIDTH-1:0]         trc_ts,
   output logic [3:0]                  spy_full,
   output logic [4*DROP_CNT_WIDTH-1:0] drop_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] pl;
      logic                  last;
      logic [TS_WIDTH-1:0]   ts;
   } rec_t;

   logic [TS_WIDTH-1:0]       ts_q;
   rec_t                      mem_q [4][FIFO_DEPTH];
   logic [PW-1:0]             wp_q [4];
   logic [PW-1:0]             rp_q [4];
   logic [CW-1:0]             cnt_q [4];
   logic [DROP_CNT_WIDTH-1:0] dcnt_q [4];
   rec_t                      slot_q;
   logic                      vld_q;
   logic [1:0]                chan_q;
   logic [1:0]                ptr_q;

   rec_t       in_rec [4];
   logic [3:0] hs, idok, cap, full, push, drop, pop;
   logic       load, found;
   logic [1:0] gnt, chn;

   always_comb begin
      hs = {WVALID & WREADY, RVALID & RREADY,
            AWVALID & AWREADY, ARVALID & ARREADY};
      in_rec[0] = '{id: ARID, pl: DATA_WIDTH'(ARADDR), last: 1'b0, ts: ts_q};
      in_rec[1] = '{id: AWID, pl: DATA_WIDTH'(AWADDR), last: 1'b0, ts: ts_q};
      in_rec[2] = '{id: RID, pl: RDATA, last: RLAST, ts: ts_q};
      in_rec[3] = '{id: WID, pl: WDATA, last: WLAST, ts: ts_q};
`ifdef AXI_SPY_ID_FILTER_EN
      for (int c = 0; c < 4; c++)
         idok[c] = (in_rec[c].id & id_mask) == (id_match & id_mask);
`else
      idok = 4'hf;
`endif
      cap = hs & idok & {4{spy_en}};
      for (int c = 0; c < 4; c++)
         full[c] = cnt_q[c] == FULL_CNT;
      // a capture into a full FIFO is lost even if it pops this cycle
      push = cap & ~full;
      drop = cap & full;
   end

   always_comb begin
      load  = ~vld_q | trc_ready;
      found = 1'b0;
      gnt   = ptr_q;
      chn   = ptr_q;
      for (int k = 0; k < 4; k++) begin
         chn = ptr_q + 2'(k);
         if (!found && cnt_q[chn] != '0) begin
            found = 1'b1;
            gnt   = chn;
         end
      end
      pop = (load && found) ? (4'b0001 << gnt) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) begin
            wp_q[c]  <= '0;
            rp_q[c]  <= '0;
            cnt_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (push[c]) begin
               mem_q[c][wp_q[c]] <= in_rec[c];
               wp_q[c] <= wp_q[c] + 1'b1;
            end
            if (pop[c])
               rp_q[c] <= rp_q[c] + 1'b1;
            cnt_q[c] <= cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         chan_q <= 2'd0;
         slot_q <= '0;
         ptr_q  <= 2'd0;
      end else if (load) begin
         vld_q <= found;
         if (found) begin
            chan_q <= gnt;
            slot_q <= mem_q[gnt][rp_q[gnt]];
            ptr_q  <= gnt + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_q <= '0;
         for (int c = 0; c < 4; c++)
            dcnt_q[c] <= '0;
      end else begin
         ts_q <= ts_q + 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (cnt_clr)
               dcnt_q[c] <= '0;
            else if (drop[c] && dcnt_q[c] != '1)
               dcnt_q[c] <= dcnt_q[c] + 1'b1;
         end
      end
   end

   always_comb begin
      trc_valid   = vld_q;
      trc_chan    = chan_q;
      trc_id      = slot_q.id;
      trc_payload = slot_q.pl;
      trc_last    = slot_q.last;
      trc_ts      = slot_q.ts;
      spy_full    = full;
      drop_cnt    = '0;
      for (int c = 0; c < 4; c++)
         drop_cnt[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = dcnt_q[c];
   end

endmodule

// File: tb/tb_axi_spy_trace.sv
// Scoreboard bench for axi_spy_trace: directed scenarios plus randomized AXI traffic.
// Occupancy/arbitration model uses per-channel counts; records are checked per channel.
module tb_axi_spy_trace;

   localparam int IW  = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int FD  = 4;
   localparam int TW  = 16;
   localparam int DCW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, spy_en, cnt_clr;
   logic ARVALID, ARREADY, AWVALID, AWREADY;
   logic RVALID, RREADY, RLAST, WVALID, WREADY, WLAST;
   logic [IW-1:0] ARID, AWID, RID, WID;
   logic [AW-1:0] ARADDR, AWADDR;
   logic [DW-1:0] RDATA, WDATA;
   logic trc_valid, trc_ready, trc_last;
   logic [1:0] trc_chan;
   logic [IW-1:0] trc_id;
   logic [DW-1:0] trc_payload;
   logic [TW-1:0] trc_ts;
   logic [3:0] spy_full;
   logic [4*DCW-1:0] drop_cnt;
`ifdef AXI_SPY_ID_FILTER_EN
   logic [IW-1:0] id_match, id_mask;
`endif

   axi_spy_trace dut (
      .clk(clk), .rst_n(rst_n), .spy_en(spy_en), .cnt_clr(cnt_clr),
`ifdef AXI_SPY_ID_FILTER_EN
      .id_match(id_match), .id_mask(id_mask),
`endif
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_chan(trc_chan),
      .trc_id(trc_id), .trc_payload(trc_payload), .trc_last(trc_last),
      .trc_ts(trc_ts), .spy_full(spy_full), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] pl;
      logic          last;
      logic [TW-1:0] ts;
   } rec_t;

   rec_t sb [4][$];
   int occ [4];
   int drops [4];
   bit slot_v;
   int slot_chan;
   int ptr;
   logic [TW-1:0] mts;
   bit mon_en = 1'b0;
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit pass_filter(input logic [IW-1:0] id);
`ifdef AXI_SPY_ID_FILTER_EN
      return (id & id_mask) == (id_match & id_mask);
`else
      return id == id;
`endif
   endfunction

   // Reference behaviour for the edge that ends the current cycle.
   task automatic model_step();
      bit   cap [4];
      bit   fullp [4];
      rec_t r [4];
      int   c;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            occ[i] = 0;
            drops[i] = 0;
         end
         slot_v = 1'b0;
         slot_chan = 0;
         ptr = 0;
         mts = '0;
         return;
      end
      cap[0] = ARVALID && ARREADY && spy_en && pass_filter(ARID);
      cap[1] = AWVALID && AWREADY && spy_en && pass_filter(AWID);
      cap[2] = RVALID && RREADY && spy_en && pass_filter(RID);
      cap[3] = WVALID && WREADY && spy_en && pass_filter(WID);
      r[0] = '{id: ARID, pl: DW'(ARADDR), last: 1'b0, ts: mts};
      r[1] = '{id: AWID, pl: DW'(AWADDR), last: 1'b0, ts: mts};
      r[2] = '{id: RID, pl: RDATA, last: RLAST, ts: mts};
      r[3] = '{id: WID, pl: WDATA, last: WLAST, ts: mts};
      for (int i = 0; i < 4; i++)
         fullp[i] = occ[i] == FD;
      if (!slot_v || trc_ready) begin
         slot_v = 1'b0;
         for (int k = 0; k < 4; k++) begin
            c = (ptr + k) % 4;
            if (occ[c] > 0) begin
               occ[c]--;
               slot_v = 1'b1;
               slot_chan = c;
               ptr = (c + 1) % 4;
               break;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (cap[i]) begin
            if (fullp[i]) begin
               if (drops[i] < (1 << DCW) - 1) drops[i]++;
            end else begin
               occ[i]++;
               sb[i].push_back(r[i]);
            end
         end
      end
      if (cnt_clr)
         for (int i = 0; i < 4; i++) drops[i] = 0;
      mts = mts + 1'b1;
   endtask

   always @(negedge clk) begin
      rec_t e;
      if (mon_en) begin
         chk("trc_valid", DW'(trc_valid), DW'(slot_v));
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("spy_full[%0d]", c), DW'(spy_full[c]), DW'(occ[c] == FD));
            chk($sformatf("drop_cnt[%0d]", c), DW'(drop_cnt[c*DCW +: DCW]), DW'(drops[c]));
         end
         if (trc_valid && slot_v)
            chk("trc_chan", DW'(trc_chan), DW'(slot_chan));
         if (trc_valid && trc_ready) begin
            if (sb[trc_chan].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_record: chan %0d got record, expected none", trc_chan);
            end else begin
               e = sb[trc_chan].pop_front();
               chk("rec_id", DW'(trc_id), DW'(e.id));
               chk("rec_payload", trc_payload, e.pl);
               chk("rec_last", DW'(trc_last), DW'(e.last));
               chk("rec_ts", DW'(trc_ts), DW'(e.ts));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle();
      ARVALID = 0; AWVALID = 0; RVALID = 0; WVALID = 0;
      ARREADY = 0; AWREADY = 0; RREADY = 0; WREADY = 0;
      RLAST = 0; WLAST = 0; cnt_clr = 0;
   endtask

   task automatic drain(input int n);
      idle();
      trc_ready = 1;
      repeat (n) step();
   endtask

   task automatic ar(input logic [IW-1:0] id, input logic [AW-1:0] addr);
      ARVALID = 1; ARREADY = 1; ARID = id; ARADDR = addr;
   endtask

   initial begin
      logic [TW-1:0] t;
      rst_n = 0; spy_en = 1; trc_ready = 0;
      ARID = 0; AWID = 0; RID = 0; WID = 0;
      ARADDR = 0; AWADDR = 0; RDATA = 0; WDATA = 0;
`ifdef AXI_SPY_ID_FILTER_EN
      id_match = 0; id_mask = 0;
`endif
      idle();
      step();
      step();
      mon_en = 1;
      chk("rst_valid", DW'(trc_valid), 0);
      chk("rst_id", DW'(trc_id), 0);
      chk("rst_payload", trc_payload, 0);
      chk("rst_ts", DW'(trc_ts), 0);
      chk("rst_full", DW'(spy_full), 0);
      chk("rst_drop", DW'(drop_cnt), 0);
      rst_n = 1;

      // single AR, two-cycle latency
      trc_ready = 1;
      t = mts;
      ar(3, 32'h40);
      step();
      idle();
      chk("t1_n1_valid", DW'(trc_valid), 0);
      step();
      chk("t1_valid", DW'(trc_valid), 1);
      chk("t1_chan", DW'(trc_chan), 0);
      chk("t1_id", DW'(trc_id), 3);
      chk("t1_payload", trc_payload, 64'h40);
      chk("t1_last", DW'(trc_last), 0);
      chk("t1_ts", DW'(trc_ts), DW'(t));
      drain(4);

      // overflow with sink stalled
      trc_ready = 0;
      for (int i = 0; i < 7; i++) begin
         ar(IW'(i), AW'(32'h100 + i));
         step();
      end
      idle();
      step();
      chk("t2_full", DW'(spy_full[0]), 1);
      chk("t2_drop", DW'(drop_cnt[DCW-1:0]), 2);
      drain(8);
      chk("t2_drop_after", DW'(drop_cnt[DCW-1:0]), 2);

      // disabled capture, then clear
      spy_en = 0;
      ar(9, 32'h99);
      step();
      spy_en = 1;
      drain(3);
      chk("t5_nodrop", DW'(drop_cnt[DCW-1:0]), 2);
      chk("t5_norec", DW'(trc_valid), 0);
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      chk("t5_clr", DW'(drop_cnt[DCW-1:0]), 0);

      // drop coinciding with clear
      trc_ready = 0;
      for (int i = 0; i < 7; i++) begin
         ar(IW'(i), AW'(i));
         cnt_clr = (i == 6);
         step();
      end
      idle();
      chk("clr_vs_drop", DW'(drop_cnt[DCW-1:0]), 0);
      drain(8);

      // drop counter saturation
      trc_ready = 0;
      for (int i = 0; i < 300; i++) begin
         ar(IW'(i), AW'(i));
         step();
      end
      idle();
      step();
      chk("sat_drop", DW'(drop_cnt[DCW-1:0]), 255);
      cnt_clr = 1;
      step();
      drain(8);

      // all four channels in one cycle
      ar(1, 32'hA0);
      AWVALID = 1; AWREADY = 1; AWID = 2; AWADDR = 32'hB0;
      RVALID = 1; RREADY = 1; RID = 3; RDATA = 64'hC0; RLAST = 1;
      WVALID = 1; WREADY = 1; WID = 4; WDATA = 64'hD0; WLAST = 1;
      step();
      drain(8);

      // parallel R and W bursts
      for (int b = 0; b < 4; b++) begin
         RVALID = 1; RREADY = 1; RID = 5; RDATA = {$urandom, $urandom};
         RLAST = (b == 3);
         WVALID = 1; WREADY = 1; WID = 6; WDATA = {$urandom, $urandom};
         WLAST = (b == 3);
         step();
      end
      drain(12);

      // reset while records are held
      trc_ready = 0;
      ar(7, 32'h70);
      AWVALID = 1; AWREADY = 1; AWID = 8; AWADDR = 32'h80;
      RVALID = 1; RREADY = 1; RID = 9; RDATA = 64'h90;
      step();
      idle();
      step();
      step();
      rst_n = 0;
      step();
      chk("t6_valid", DW'(trc_valid), 0);
      chk("t6_full", DW'(spy_full), 0);
      chk("t6_drop", DW'(drop_cnt), 0);
      rst_n = 1;
      trc_ready = 1;
      ar(5, 32'h55);
      step();
      idle();
      step();
      chk("t6_ts0", DW'(trc_ts), 0);
      drain(4);

`ifdef AXI_SPY_ID_FILTER_EN
      id_mask = 4'hF;
      id_match = 4'h2;
      for (int i = 1; i <= 3; i++) begin
         ar(IW'(i), AW'(32'h200 + i));
         step();
      end
      drain(6);
      id_mask = 0;
      id_match = 0;
`endif

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         ARVALID = 1'($urandom); ARREADY = 1'($urandom);
         AWVALID = 1'($urandom); AWREADY = 1'($urandom);
         RVALID = 1'($urandom); RREADY = 1'($urandom);
         WVALID = 1'($urandom); WREADY = 1'($urandom);
         ARID = IW'($urandom); AWID = IW'($urandom);
         RID = IW'($urandom); WID = IW'($urandom);
         ARADDR = $urandom; AWADDR = $urandom;
         RDATA = {$urandom, $urandom}; WDATA = {$urandom, $urandom};
         RLAST = 1'($urandom); WLAST = 1'($urandom);
         trc_ready = $urandom_range(0, 3) != 0;
         spy_en = $urandom_range(0, 15) != 0;
         cnt_clr = $urandom_range(0, 31) == 0;
         step();
      end
      spy_en = 1;
      drain(40);
      for (int c = 0; c < 4; c++)
         chk($sformatf("leftover[%0d]", c), DW'(sb[c].size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
